// File: rtl/sync_fifo.sv
// Single-clock byte FIFO: circular buffer with registered read data, occupancy count and
// full/empty flags. Requests that cannot be honoured (write when full, read when empty) are dropped.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic [ADDR_WIDTH:0]   fifo_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FullCnt = (ADDR_WIDTH + 1)'(Depth);
  localparam logic [ADDR_WIDTH:0]   CntOne  = 1;
  localparam logic [ADDR_WIDTH-1:0] PtrOne  = 1;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_out_q, buf_out_d;
  logic                  wr_accept, rd_accept;

  assign buf_empty = (cnt_q == '0);
  assign buf_full  = (cnt_q == FullCnt);
  assign fifo_cnt  = cnt_q;
  assign buf_out   = buf_out_q;

  // Gating on the flags makes simultaneous requests resolve correctly at both extremes.
  assign wr_accept = wr_en && !buf_full;
  assign rd_accept = rd_en && !buf_empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    buf_out_d = buf_out_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + PtrOne;
      buf_out_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      buf_out_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      buf_out_q <= buf_out_d;
    end
  end

  // Storage is deliberately not reset; only pointers and count define valid contents.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= buf_in;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus biased random traffic, all checked against a
// queue-based reference model.
module tb_sync_fifo;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned AddrWidth = 3;
  localparam int unsigned Depth     = 2 ** AddrWidth;

  logic                 clock;
  logic                 reset;
  logic [DataWidth-1:0] buf_in;
  logic                 wr_en;
  logic                 rd_en;
  logic [DataWidth-1:0] buf_out;
  logic                 buf_empty;
  logic                 buf_full;
  logic [AddrWidth:0]   fifo_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: contents in arrival order plus the last value read out.
  logic [DataWidth-1:0] model_q[$];
  logic [DataWidth-1:0] model_out;

  sync_fifo #(
    .DATA_WIDTH(DataWidth),
    .ADDR_WIDTH(AddrWidth)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .buf_in   (buf_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .buf_out  (buf_out),
    .buf_empty(buf_empty),
    .buf_full (buf_full),
    .fifo_cnt (fifo_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int unsigned n;
    n = model_q.size();
    check($sformatf("%s.out", tag), 32'(buf_out), 32'(model_out));
    check($sformatf("%s.cnt", tag), 32'(fifo_cnt), n);
    check($sformatf("%s.empty", tag), 32'(buf_empty), 32'(n == 0));
    check($sformatf("%s.full", tag), 32'(buf_full), 32'(n == Depth));
  endtask

  // One clock with the given requests; model updated from the pre-edge occupancy.
  task automatic step(input string tag, input logic wr, input logic rd,
                      input logic [DataWidth-1:0] din);
    bit wr_ok, rd_ok;
    wr_en  = wr;
    rd_en  = rd;
    buf_in = din;
    wr_ok  = wr && (model_q.size() < Depth);
    rd_ok  = rd && (model_q.size() > 0);
    @(posedge clock);
    #1;
    if (rd_ok) model_out = model_q.pop_front();
    if (wr_ok) model_q.push_back(din);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state(tag);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b0;
    model_q.delete();
    model_out = '0;
    #1;
    check_state(tag);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [DataWidth-1:0] vals[7];
    int unsigned wp, rp;
    vals = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
    reset  = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    buf_in = '0;
    model_out = '0;

    #3;
    check_state("reset");
    check("reset.out_zero", 32'(buf_out), 32'd0);
    #3;
    reset = 1'b1;
    step("idle0", 1'b0, 1'b0, 8'd0);
    step("idle1", 1'b0, 1'b0, 8'd0);

    step("s2_wr1", 1'b1, 1'b0, 8'd1);
    step("s2_both", 1'b1, 1'b1, 8'd2);
    check("s2_both.out1", 32'(buf_out), 32'd1);

    foreach (vals[i]) step("s3_fill", 1'b1, 1'b0, vals[i]);
    check("s3.full", 32'(buf_full), 32'd1);
    step("s3_wr_full", 1'b1, 1'b0, 8'd80);
    check("s3.cnt8", 32'(fifo_cnt), 32'd8);

    step("s4_rd", 1'b0, 1'b1, 8'd0);
    check("s4.out2", 32'(buf_out), 32'd2);
    step("s4_wr", 1'b1, 1'b0, 8'd2);
    for (int i = 0; i < 8; i++) step("s4_drain", 1'b0, 1'b1, 8'd0);
    check("s4.last2", 32'(buf_out), 32'd2);

    step("s5_wr", 1'b1, 1'b0, 8'd140);
    step("s5_rd", 1'b0, 1'b1, 8'd0);
    check("s5.out140", 32'(buf_out), 32'd140);
    step("s5_rd_empty", 1'b0, 1'b1, 8'd0);
    check("s5.hold140", 32'(buf_out), 32'd140);
    step("s5_wr5", 1'b1, 1'b0, 8'd5);
    step("s5_rd5", 1'b0, 1'b1, 8'd0);
    check("s5.out5", 32'(buf_out), 32'd5);

    for (int i = 0; i < 8; i++) step("s6_fill", 1'b1, 1'b0, 8'(100 + i));
    step("s6_both_full", 1'b1, 1'b1, 8'd99);
    check("s6.out100", 32'(buf_out), 32'd100);
    check("s6.cnt7", 32'(fifo_cnt), 32'd7);
    step("s6_wr", 1'b1, 1'b0, 8'd33);
    apply_reset("s6_rst_mid");
    step("s6_wr9", 1'b1, 1'b0, 8'd9);
    step("s6_rd9", 1'b0, 1'b1, 8'd0);
    check("s6.out9", 32'(buf_out), 32'd9);

    // Random traffic in phases biased toward filling, draining, and balanced operation.
    for (int i = 0; i < 600; i++) begin
      case ((i / 40) % 3)
        0:       begin wp = 80; rp = 25; end
        1:       begin wp = 25; rp = 80; end
        default: begin wp = 50; rp = 50; end
      endcase
      step("rand", ($urandom_range(99) < wp), ($urandom_range(99) < rp),
           DataWidth'($urandom));
      if (i == 317) apply_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
